windowed_peak_detector: RTL and testbench
=========================================

Name: windowed_peak_detector

Overview:
Parametrised successor to the single-word ADC peak detector. It takes LANES signed samples per clock from the shifted ADC stream and finds the largest-magnitude sample over a programmable window of consecutive words. It reports the signed sample, its magnitude, its lane and word position, and a threshold flag through a valid/ready output that feeds the input lookup table or the experiment FSM. A sticky overrun flag records results that were dropped because of backpressure.

Parameters:
SAMPLE_W, 16, bits per signed two's-complement sample
LANES, 8, samples per input word (power of 2, at least 2)
WIN_W, 8, width of the window-length input and of the word-index output

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
s_tdata  in  SAMPLE_W*LANES  input word; lane i occupies bits [i*SAMPLE_W +: SAMPLE_W]
s_tvalid  in  1  word valid; no input backpressure
run  in  1  detection enable from FSM
win_len  in  WIN_W  words per window; sampled at window start; 0 is treated as 1
threshold  in  SAMPLE_W  unsigned magnitude threshold
m_peak  out  SAMPLE_W  signed raw sample at the peak
m_mag  out  SAMPLE_W  unsigned magnitude at the peak
m_lane  out  $clog2(LANES)  lane index of the peak
m_word  out  WIN_W  word offset of the peak within the window (0-based)
m_above  out  1  m_mag >= threshold
m_valid  out  1  result valid
m_ready  in  1  consumer accepts the result
overrun  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset: every output is 0; pipeline valid bits are 0; window counter is 0; the accumulator is empty.
- A word is accepted in cycle k when s_tvalid && run.
- Stage 1 (registered):
  - per-lane magnitude = sample if sample >= 0, otherwise -sample, as an unsigned SAMPLE_W-bit value.
  - -2^(SAMPLE_W-1) gives 2^(SAMPLE_W-1) exactly (0x8000 for 16 bits), with no saturation.
  - The raw word is carried alongside the magnitudes.
- Stage 2 (registered): balanced log2(LANES) compare tree.
  - A lane wins only on strictly greater magnitude, so ties go to the lowest lane index.
- Stage 3 (window accumulator):
  - The first word of a window loads the accumulator unconditionally and latches win_len (0 becomes 1).
  - Each later word replaces the accumulator only if its magnitude is strictly greater, so ties keep the earliest word.
  - The word counter increments on every accepted word.
  - When the count reaches the latched length, the accumulator is copied to the output registers, m_valid is set, and the counter returns to 0.
- Latency: the last word of a window accepted in cycle k produces m_valid=1 in cycle k+3.
- Back-to-back windows have no dead cycles; the next window's first word may arrive in cycle k+1.
- Gaps: s_tvalid=0 cycles inside a window (with run=1) are skipped; the window spans accepted words only.
- Output handshake:
  - m_valid falls on the cycle after m_valid && m_ready.
  - Output registers are stable while m_valid=1 and m_ready=0, unless overwritten as below.
- Overrun:
  - A new result completing while m_valid=1 and m_ready=0 overwrites the outputs, keeps m_valid=1, and sets overrun=1.
  - If m_ready=1 in that same cycle, the old result is taken, the new one loads, m_valid stays 1, and overrun is not set.
- run deasserted mid-window:
  - All stage valids are cleared and the partial window is discarded with no output.
  - The counter resets, and the next word accepted after run rises starts a new window.
  - A result already in the output register is unaffected.
- win_len or threshold changing mid-window has no effect until the next window start.
  - m_above is computed when the result loads, using the threshold latched at that window's start.
- Synchronous rst mid-operation:
  - Flushes the pipeline, the accumulator and the output on the next edge.
  - m_valid=0 and overrun=0 from the following cycle.

Test Plan:
- Single-word window: win_len=1; lanes {10,-300,200,0,5,-5,7,299}; one valid cycle -> m_valid three cycles later; m_peak=-300, m_mag=300, m_lane=1, m_word=0.
- Most-negative value: lane 6 = 0x8000, all others 0x7FFF -> m_mag=0x8000, m_lane=6, m_peak=0x8000.
- Ties and window:
  - win_len=4; words whose maxima are 50 at word 1 lane 3 and 50 at word 3 lane 0 -> m_word=1, m_lane=3.
  - Equal lanes inside one word -> lowest lane is reported.
- Gaps and abort:
  - win_len=3 with one s_tvalid=0 bubble inside -> result covers 3 accepted words.
  - run dropped after 2 words -> no m_valid; restart yields a fresh window with m_word counted from 0.
- Backpressure:
  - win_len=1, m_ready=0, two results in consecutive windows -> second result overwrites the first, overrun=1.
  - With m_ready=1 in the collision cycle -> overrun stays 0.
- Reset and threshold: threshold=100 with peak 99 -> m_above=0; peak 100 -> m_above=1. Assert rst mid-window -> all outputs 0 next cycle; no stale result afterwards.

Source files
------------

// File: rtl/windowed_peak_detector.sv
// Windowed peak detector: finds the largest-magnitude signed sample over a
// programmable number of accepted multi-lane words and reports it via valid/ready.
module windowed_peak_detector #(
    parameter  int SAMPLE_W = 16,
    parameter  int LANES    = 8,
    parameter  int WIN_W    = 8,
    localparam int LW       = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_W*LANES-1:0] s_tdata,
    input  logic                      s_tvalid,
    input  logic                      run,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [SAMPLE_W-1:0]       threshold,
    output logic [SAMPLE_W-1:0]       m_peak,
    output logic [SAMPLE_W-1:0]       m_mag,
    output logic [LW-1:0]             m_lane,
    output logic [WIN_W-1:0]          m_word,
    output logic                      m_above,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      overrun
);

    logic [SAMPLE_W-1:0]       in_mag [LANES];
    logic                      s1_valid;
    logic [SAMPLE_W*LANES-1:0] s1_data;
    logic [SAMPLE_W-1:0]       s1_mag [LANES];
    logic [WIN_W-1:0]          s1_len;
    logic [SAMPLE_W-1:0]       s1_thr;

    logic [SAMPLE_W-1:0]       t_mag  [2*LANES];
    logic [LW-1:0]             t_lane [2*LANES];
    logic [SAMPLE_W-1:0]       win_peak;

    logic                      s2_valid;
    logic [SAMPLE_W-1:0]       s2_peak;
    logic [SAMPLE_W-1:0]       s2_mag;
    logic [LW-1:0]             s2_lane;
    logic [WIN_W-1:0]          s2_len;
    logic [SAMPLE_W-1:0]       s2_thr;

    logic [WIN_W-1:0]          cnt;
    logic [WIN_W-1:0]          len_lat;
    logic [SAMPLE_W-1:0]       thr_lat;
    logic [SAMPLE_W-1:0]       acc_peak;
    logic [SAMPLE_W-1:0]       acc_mag;
    logic [LW-1:0]             acc_lane;
    logic [WIN_W-1:0]          acc_word;

    logic                      first;
    logic                      take;
    logic                      done;
    logic [WIN_W:0]            cnt_nxt;
    logic [WIN_W-1:0]          cur_len;
    logic [SAMPLE_W-1:0]       cur_thr;
    logic [SAMPLE_W-1:0]       cand_peak;
    logic [SAMPLE_W-1:0]       cand_mag;
    logic [LW-1:0]             cand_lane;
    logic [WIN_W-1:0]          cand_word;

    // Two's-complement negate: the most negative value maps to 2^(SAMPLE_W-1) unsigned.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (s_tdata[i*SAMPLE_W + SAMPLE_W-1])
                in_mag[i] = ~s_tdata[i*SAMPLE_W +: SAMPLE_W] + SAMPLE_W'(1);
            else
                in_mag[i] = s_tdata[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_len   <= '0;
            s1_thr   <= '0;
            for (int i = 0; i < LANES; i++) s1_mag[i] <= '0;
        end else begin
            s1_valid <= s_tvalid && run;
            if (s_tvalid && run) begin
                s1_data <= s_tdata;
                s1_len  <= win_len;
                s1_thr  <= threshold;
                for (int i = 0; i < LANES; i++) s1_mag[i] <= in_mag[i];
            end
        end
    end

    // Heap-indexed compare tree: node n merges 2n (lower lanes) and 2n+1.
    always_comb begin
        for (int n = 0; n < 2*LANES; n++) begin
            t_mag[n]  = '0;
            t_lane[n] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            t_mag[LANES+i]  = s1_mag[i];
            t_lane[LANES+i] = LW'(i);
        end
        for (int n = LANES-1; n >= 1; n--) begin
            if (t_mag[2*n+1] > t_mag[2*n]) begin
                t_mag[n]  = t_mag[2*n+1];
                t_lane[n] = t_lane[2*n+1];
            end else begin
                t_mag[n]  = t_mag[2*n];
                t_lane[n] = t_lane[2*n];
            end
        end
        win_peak = s1_data[t_lane[1]*SAMPLE_W +: SAMPLE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_peak  <= '0;
            s2_mag   <= '0;
            s2_lane  <= '0;
            s2_len   <= '0;
            s2_thr   <= '0;
        end else begin
            s2_valid <= s1_valid && run;
            if (s1_valid) begin
                s2_peak <= win_peak;
                s2_mag  <= t_mag[1];
                s2_lane <= t_lane[1];
                s2_len  <= s1_len;
                s2_thr  <= s1_thr;
            end
        end
    end

    // Window length and threshold come from the window's first word, so
    // later changes on the inputs only affect the next window.
    always_comb begin
        first     = (cnt == '0);
        cur_len   = first ? ((s2_len == '0) ? WIN_W'(1) : s2_len) : len_lat;
        cur_thr   = first ? s2_thr : thr_lat;
        take      = first || (s2_mag > acc_mag);
        cand_peak = take ? s2_peak : acc_peak;
        cand_mag  = take ? s2_mag  : acc_mag;
        cand_lane = take ? s2_lane : acc_lane;
        cand_word = take ? cnt     : acc_word;
        cnt_nxt   = {1'b0, cnt} + 1'b1;
        done      = s2_valid && run && (cnt_nxt == {1'b0, cur_len});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            len_lat  <= '0;
            thr_lat  <= '0;
            acc_peak <= '0;
            acc_mag  <= '0;
            acc_lane <= '0;
            acc_word <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (s2_valid) begin
            cnt      <= done ? '0 : cnt_nxt[WIN_W-1:0];
            len_lat  <= cur_len;
            thr_lat  <= cur_thr;
            acc_peak <= cand_peak;
            acc_mag  <= cand_mag;
            acc_lane <= cand_lane;
            acc_word <= cand_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_peak  <= '0;
            m_mag   <= '0;
            m_lane  <= '0;
            m_word  <= '0;
            m_above <= 1'b0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (done) begin
            m_peak  <= cand_peak;
            m_mag   <= cand_mag;
            m_lane  <= cand_lane;
            m_word  <= cand_word;
            m_above <= (cand_mag >= cur_thr);
            m_valid <= 1'b1;
            if (m_valid && !m_ready) overrun <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_windowed_peak_detector.sv
// Directed bench for windowed_peak_detector with hand-computed expectations.
module tb_windowed_peak_detector;

    localparam int SW = 16;
    localparam int L  = 8;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW*L-1:0] s_tdata;
    logic          s_tvalid;
    logic          run;
    logic [WW-1:0] win_len;
    logic [SW-1:0] threshold;
    logic [SW-1:0] m_peak;
    logic [SW-1:0] m_mag;
    logic [2:0]    m_lane;
    logic [WW-1:0] m_word;
    logic          m_above;
    logic          m_valid;
    logic          m_ready;
    logic          overrun;

    int total  = 0;
    int passed = 0;

    windowed_peak_detector #(.SAMPLE_W(SW), .LANES(L), .WIN_W(WW)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .run(run),
        .win_len(win_len), .threshold(threshold), .m_peak(m_peak), .m_mag(m_mag),
        .m_lane(m_lane), .m_word(m_word), .m_above(m_above), .m_valid(m_valid),
        .m_ready(m_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [SW*L-1:0] mkw(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7);
        int v[8];
        logic [SW*L-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        w = '0;
        for (int i = 0; i < L; i++) w[i*SW +: SW] = v[i][SW-1:0];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW*L-1:0] w);
        s_tdata  = w;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic consume(input string name);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0) $display("FAIL %s_consume m_valid got %b exp 0", name, m_valid);
        else passed++;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tvalid = 1'b0; run = 1'b1; m_ready = 1'b0;
        win_len = 8'd1; threshold = 16'd100; s_tdata = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({m_valid, overrun, m_above} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {m_valid, overrun, m_above});
        else passed++;
        total++;
        if ({m_peak, m_mag, m_lane, m_word} !== '0) $display("FAIL reset_data got %h exp 0", {m_peak, m_mag, m_lane, m_word});
        else passed++;
    endtask

    task automatic test_single();
        win_len = 8'd1; threshold = 16'd100;
        send(mkw(10, -300, 200, 0, 5, -5, 7, 299));
        total++;
        if (m_valid !== 1'b0) $display("FAIL single_lat1 m_valid got %b exp 0", m_valid); else passed++;
        step();
        total++;
        if (m_valid !== 1'b0) $display("FAIL single_lat2 m_valid got %b exp 0", m_valid); else passed++;
        step();
        total++;
        if (m_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", m_valid); else passed++;
        total++;
        if ({m_peak, m_mag, m_lane, m_word, m_above} !== {16'hFED4, 16'd300, 3'd1, 8'd0, 1'b1})
            $display("FAIL single_result got peak=%h mag=%0d lane=%0d word=%0d above=%b exp peak=fed4 mag=300 lane=1 word=0 above=1",
                     m_peak, m_mag, m_lane, m_word, m_above);
        else passed++;
        step();
        total++;
        if ({m_valid, m_mag} !== {1'b1, 16'd300}) $display("FAIL single_hold got v=%b mag=%0d exp v=1 mag=300", m_valid, m_mag);
        else passed++;
        consume("single");
    endtask

    task automatic test_most_negative();
        send(mkw(32767, 32767, 32767, 32767, 32767, 32767, -32768, 32767));
        step(); step();
        total++;
        if ({m_valid, m_peak, m_mag, m_lane} !== {1'b1, 16'h8000, 16'h8000, 3'd6})
            $display("FAIL mostneg got v=%b peak=%h mag=%h lane=%0d exp v=1 peak=8000 mag=8000 lane=6",
                     m_valid, m_peak, m_mag, m_lane);
        else passed++;
        consume("mostneg");
    endtask

    task automatic test_word_tie();
        send(mkw(-7, 7, -7, 7, -7, 7, -7, 7));
        step(); step();
        total++;
        if ({m_valid, m_peak, m_lane} !== {1'b1, 16'hFFF9, 3'd0})
            $display("FAIL word_tie got v=%b peak=%h lane=%0d exp v=1 peak=fff9 lane=0", m_valid, m_peak, m_lane);
        else passed++;
        consume("word_tie");
    endtask

    task automatic test_window_tie();
        win_len = 8'd4;
        send(mkw(20, 0, 0, 0, 0, 0, 0, 0));
        send(mkw(10, 10, 10, 50, 10, -50, 10, 10));
        send(mkw(0, 30, 0, 0, 0, 0, 0, 0));
        send(mkw(50, 0, 0, 0, 0, 0, 0, 0));
        step();
        total++;
        if (m_valid !== 1'b0) $display("FAIL wtie_early m_valid got %b exp 0", m_valid); else passed++;
        step();
        total++;
        if ({m_valid, m_peak, m_mag, m_lane, m_word} !== {1'b1, 16'd50, 16'd50, 3'd3, 8'd1})
            $display("FAIL wtie_result got v=%b peak=%h mag=%0d lane=%0d word=%0d exp v=1 peak=0032 mag=50 lane=3 word=1",
                     m_valid, m_peak, m_mag, m_lane, m_word);
        else passed++;
        consume("wtie");
    endtask

    task automatic test_gap();
        win_len = 8'd3;
        send(mkw(0, 0, 40, 0, 0, 0, 0, 0));
        win_len = 8'd1;
        step();
        send(mkw(0, 0, 0, 0, 0, 0, 0, -60));
        total++;
        if (m_valid !== 1'b0) $display("FAIL gap_midwin m_valid got %b exp 0", m_valid); else passed++;
        send(mkw(10, 0, 0, 0, 0, 0, 0, 0));
        step();
        total++;
        if (m_valid !== 1'b0) $display("FAIL gap_early m_valid got %b exp 0", m_valid); else passed++;
        step();
        total++;
        if ({m_valid, m_peak, m_mag, m_lane, m_word, m_above} !== {1'b1, 16'hFFC4, 16'd60, 3'd7, 8'd1, 1'b0})
            $display("FAIL gap_result got v=%b peak=%h mag=%0d lane=%0d word=%0d above=%b exp v=1 peak=ffc4 mag=60 lane=7 word=1 above=0",
                     m_valid, m_peak, m_mag, m_lane, m_word, m_above);
        else passed++;
        consume("gap");
    endtask

    task automatic test_threshold();
        win_len = 8'd1; threshold = 16'd100;
        send(mkw(0, 99, 0, 0, 0, 0, 0, 0));
        step(); step();
        total++;
        if ({m_valid, m_mag, m_above} !== {1'b1, 16'd99, 1'b0})
            $display("FAIL thr_99 got v=%b mag=%0d above=%b exp v=1 mag=99 above=0", m_valid, m_mag, m_above);
        else passed++;
        consume("thr99");
        send(mkw(0, 0, 0, -100, 0, 0, 0, 0));
        threshold = 16'd200;
        step(); step();
        total++;
        if ({m_valid, m_peak, m_mag, m_above} !== {1'b1, 16'hFF9C, 16'd100, 1'b1})
            $display("FAIL thr_100 got v=%b peak=%h mag=%0d above=%b exp v=1 peak=ff9c mag=100 above=1",
                     m_valid, m_peak, m_mag, m_above);
        else passed++;
        consume("thr100");
        threshold = 16'd100;
    endtask

    task automatic test_abort();
        win_len = 8'd4;
        send(mkw(900, 0, 0, 0, 0, 0, 0, 0));
        send(mkw(0, 900, 0, 0, 0, 0, 0, 0));
        run = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) step();
        total++;
        if (m_valid !== 1'b0) $display("FAIL abort_noout m_valid got %b exp 0", m_valid); else passed++;
        run = 1'b1; win_len = 8'd2;
        send(mkw(5, 0, 0, 0, 0, 0, 0, 0));
        send(mkw(0, 0, 0, 0, 8, 0, 0, 0));
        step(); step();
        total++;
        if ({m_valid, m_mag, m_lane, m_word} !== {1'b1, 16'd8, 3'd4, 8'd1})
            $display("FAIL abort_restart got v=%b mag=%0d lane=%0d word=%0d exp v=1 mag=8 lane=4 word=1",
                     m_valid, m_mag, m_lane, m_word);
        else passed++;
        consume("abort");
    endtask

    task automatic test_overrun();
        win_len = 8'd1; m_ready = 1'b0;
        send(mkw(0, 0, 11, 0, 0, 0, 0, 0));
        send(mkw(0, 0, 0, 0, 0, 22, 0, 0));
        step();
        total++;
        if ({m_valid, m_mag, overrun} !== {1'b1, 16'd11, 1'b0})
            $display("FAIL ovr_first got v=%b mag=%0d ovr=%b exp v=1 mag=11 ovr=0", m_valid, m_mag, overrun);
        else passed++;
        step();
        total++;
        if ({m_valid, m_mag, m_lane, overrun} !== {1'b1, 16'd22, 3'd5, 1'b1})
            $display("FAIL ovr_second got v=%b mag=%0d lane=%0d ovr=%b exp v=1 mag=22 lane=5 ovr=1",
                     m_valid, m_mag, m_lane, overrun);
        else passed++;
        consume("ovr");
        total++;
        if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid();
        win_len = 8'd1;
        send(mkw(77, 0, 0, 0, 0, 0, 0, 0));
        step(); step();
        total++;
        if ({m_valid, m_mag} !== {1'b1, 16'd77}) $display("FAIL rstmid_pre got v=%b mag=%0d exp v=1 mag=77", m_valid, m_mag);
        else passed++;
        win_len = 8'd3;
        send(mkw(0, 500, 0, 0, 0, 0, 0, 0));
        send(mkw(0, 0, 600, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({m_valid, overrun, m_above, m_peak, m_mag, m_lane, m_word} !== '0)
            $display("FAIL rstmid_out got v=%b ovr=%b above=%b peak=%h mag=%h lane=%0d word=%0d exp all 0",
                     m_valid, overrun, m_above, m_peak, m_mag, m_lane, m_word);
        else passed++;
        send(mkw(0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 6; i++) step();
        total++;
        if (m_valid !== 1'b0) $display("FAIL rstmid_stale m_valid got %b exp 0", m_valid); else passed++;
    endtask

    task automatic test_collision();
        do_reset();
        win_len = 8'd1;
        send(mkw(33, 0, 0, 0, 0, 0, 0, 0));
        send(mkw(0, 44, 0, 0, 0, 0, 0, 0));
        step();
        total++;
        if ({m_valid, m_mag} !== {1'b1, 16'd33}) $display("FAIL coll_first got v=%b mag=%0d exp v=1 mag=33", m_valid, m_mag);
        else passed++;
        m_ready = 1'b1;
        step();
        total++;
        if ({m_valid, m_mag, m_lane, overrun} !== {1'b1, 16'd44, 3'd1, 1'b0})
            $display("FAIL coll_second got v=%b mag=%0d lane=%0d ovr=%b exp v=1 mag=44 lane=1 ovr=0",
                     m_valid, m_mag, m_lane, overrun);
        else passed++;
        step();
        m_ready = 1'b0;
        total++;
        if ({m_valid, overrun} !== 2'b00) $display("FAIL coll_drain got v=%b ovr=%b exp v=0 ovr=0", m_valid, overrun);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_most_negative();
        test_word_tie();
        test_window_tie();
        test_gap();
        test_threshold();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_collision();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
